// File: rtl/serial_addsub_n.sv
// Bit-serial two's-complement adder/subtractor, one full-adder slice, LSB first.
// Latency: WIDTH+1 cycles from the accepting edge to the done pulse; one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped (no queueing).
//
// Ports:
//   i_clk, i_rstn          clock, synchronous active-low reset
//   i_start, i_sub         request; 0 = A+B, 1 = A-B (latched on accept)
//   i_op_a, i_op_b         WIDTH-bit operands (latched on accept)
//   o_busy, o_done         busy in SHIFT/DONE; done is a one-cycle pulse
//   o_result, o_cout, o_ovf  result register, carry out of MSB, signed overflow
//   o_ser_out              sum bit being produced this cycle (valid in SHIFT only)
module serial_addsub_n #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_ser_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_b_eff;
  logic w_sum;
  logic w_carry_nxt;
  logic w_last;

  // Subtraction inverts B bit by bit; the +1 comes from the carry preset on accept.
  assign w_b_eff     = r_b[0] ^ r_sub;
  assign w_sum       = r_a[0] ^ w_b_eff ^ r_carry;
  assign w_carry_nxt = (r_a[0] & w_b_eff) | (r_a[0] & r_carry) | (w_b_eff & r_carry);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_sub   <= i_sub;
            r_carry <= i_sub;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Sum bits enter at the MSB so the result ends up right-aligned in r_a.
          r_a     <= {w_sum, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // r_carry here is the carry into the MSB position.
            r_cout  <= w_carry_nxt;
            r_ovf   <= r_carry ^ w_carry_nxt;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_a;
  assign o_cout    = r_cout;
  assign o_ovf     = r_ovf;
  assign o_ser_out = w_sum;

endmodule

// File: tb/tb_serial_addsub_n.sv
// Bench for serial_addsub_n: 4-bit and 8-bit instances, vector table plus corner sequences.
// Expected results are queued at start and compared when done pulses.
// Covers latency, serial bit stream, back-to-back start, and reset mid-operation.
module tb_serial_addsub_n;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4, ser4;
  logic [3:0] res4;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8, ser8;
  logic [7:0] res8;

  serial_addsub_n #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start4), .i_sub(sub4),
    .i_op_a(a4), .i_op_b(b4), .o_busy(busy4), .o_done(done4),
    .o_result(res4), .o_cout(cout4), .o_ovf(ovf4), .o_ser_out(ser4)
  );

  serial_addsub_n #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start8), .i_sub(sub8),
    .i_op_a(a8), .i_op_b(b8), .o_busy(busy8), .o_done(done8),
    .o_result(res8), .o_cout(cout8), .o_ovf(ovf8), .o_ser_out(ser8)
  );

  typedef struct {
    bit         w8;
    logic       sb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] er;
    logic       ec;
    logic       eo;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev4 = 1'b0, prev8 = 1'b0;

  logic sel8 = 1'b0;
  logic m_busy, m_done, m_ser;
  assign m_busy = sel8 ? busy8 : busy4;
  assign m_done = sel8 ? done8 : done4;
  assign m_ser  = sel8 ? ser8  : ser4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference from plain integer arithmetic on WIDTH+1 bits.
  function automatic vec_t mk8(input logic sb, input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    logic [8:0] f;
    f = sb ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
    v.w8 = 1'b1; v.sb = sb; v.a = a; v.b = b;
    v.er = f[7:0];
    v.ec = f[8];
    v.eo = sb ? ((a[7] != b[7]) && (f[7] != a[7])) : ((a[7] == b[7]) && (f[7] != a[7]));
    return v;
  endfunction

  // Scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      chk("done4 pulse width", {31'b0, prev4}, 32'd0);
      if (q4.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done4 unexpected: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e4 = q4.pop_front();
        chk("result4", {28'b0, res4}, {24'b0, e4.res});
        chk("cout4", {31'b0, cout4}, {31'b0, e4.cout});
        chk("ovf4", {31'b0, ovf4}, {31'b0, e4.ovf});
      end
    end
    if (done8 === 1'b1) begin
      chk("done8 pulse width", {31'b0, prev8}, 32'd0);
      if (q8.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done8 unexpected: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e8 = q8.pop_front();
        chk("result8", {24'b0, res8}, {24'b0, e8.res});
        chk("cout8", {31'b0, cout8}, {31'b0, e8.cout});
        chk("ovf8", {31'b0, ovf8}, {31'b0, e8.ovf});
      end
    end
    prev4 = done4;
    prev8 = done8;
  end

  task automatic run(input vec_t v);
    int cyc;
    int w;
    logic [7:0] serb;
    w = v.w8 ? 8 : 4;
    sel8 = v.w8;
    @(posedge clk); #1;
    if (v.w8) begin
      start8 = 1'b1; sub8 = v.sb; a8 = v.a; b8 = v.b;
      q8.push_back('{v.er, v.ec, v.eo});
    end else begin
      start4 = 1'b1; sub4 = v.sb; a4 = v.a[3:0]; b4 = v.b[3:0];
      q4.push_back('{v.er, v.ec, v.eo});
    end
    @(posedge clk); #1;
    // Operands are don't-care after the accepting edge.
    start4 = 1'b0; start8 = 1'b0;
    sub4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    sub8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    chk("busy after accept", {31'b0, m_busy}, 32'd1);
    cyc = 1;
    serb = '0;
    while (m_done !== 1'b1 && cyc < 40) begin
      if (cyc <= w) serb[3'(cyc - 1)] = m_ser;
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, w + 1);
    chk("ser_out stream", {24'b0, serb}, {24'b0, v.er});
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Width-4 vectors (upper nibbles zero)
    tbl.push_back('{1'b0, 1'b1, 8'h05, 8'h07, 8'h0E, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h07, 8'h01, 8'h08, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h08, 8'h01, 8'h07, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8'h0F, 8'h01, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 8'h09, 8'h09, 8'h02, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 8'h00, 8'h01, 8'h0F, 1'b0, 1'b0});
    // Width-8 vectors
    tbl.push_back('{1'b1, 1'b0, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1});
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk8(1'($urandom), 8'($urandom), 8'($urandom)));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy4", {31'b0, busy4}, 32'd0);
    chk("rst done4", {31'b0, done4}, 32'd0);
    chk("rst result4", {28'b0, res4}, 32'd0);
    chk("rst cout4", {31'b0, cout4}, 32'd0);
    chk("rst ovf4", {31'b0, ovf4}, 32'd0);
    chk("rst ser4", {31'b0, ser4}, 32'd0);
    chk("rst busy8", {31'b0, busy8}, 32'd0);
    chk("rst result8", {24'b0, res8}, 32'd0);
    rstn = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Back-to-back: start held high; accepts only at E0 and E6.
    sel8 = 1'b0;
    @(posedge clk); #1;
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'b0011; b4 = 4'b0101;
    q4.push_back('{8'h08, 1'b0, 1'b1});
    @(posedge clk); #1;
    for (int k = 0; k <= 13; k++) begin
      chk("b2b done timing", {31'b0, done4}, {31'b0, (k == 4 || k == 10)});
      if (k == 0) begin sub4 = 1'b1; a4 = 4'b0110; b4 = 4'b0010; end
      if (k == 5) begin
        chk("b2b idle gap busy", {31'b0, busy4}, 32'd0);
        q4.push_back('{8'h04, 1'b1, 1'b0});
      end
      if (k == 6) begin
        chk("b2b second accept busy", {31'b0, busy4}, 32'd1);
        sub4 = 1'b0; a4 = 4'b1111; b4 = 4'b1111;
      end
      if (k == 11) start4 = 1'b0;
      @(posedge clk); #1;
    end

    // Reset at the second SHIFT edge discards the operation.
    @(posedge clk); #1;
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'b0111; b4 = 4'b0001;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst busy", {31'b0, busy4}, 32'd0);
    chk("midrst done", {31'b0, done4}, 32'd0);
    chk("midrst result", {28'b0, res4}, 32'd0);
    chk("midrst cout", {31'b0, cout4}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("midrst no done", {31'b0, done4}, 32'd0);
      @(posedge clk); #1;
    end
    run('{1'b0, 1'b0, 8'h03, 8'h01, 8'h04, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("q4 drained", q4.size(), 32'd0);
    chk("q8 drained", q8.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub_n.md
# serial_addsub_n

Parametrised bit-serial two's-complement adder/subtractor with a start/busy/done handshake. It loads two WIDTH-bit operands and processes one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop. Each sum bit shifts into the MSB of the A register, which holds the result when the operation ends. It serves datapaths that trade latency for area and replaces the fixed 4-bit, add-only serial unit with a generic-width add/subtract block that reports flags.

## Interface
Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rstn  input  1  reset, synchronous active-low; sampled on rising clk.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; latched with operands on accepted start.
- op_a  input  WIDTH  operand A, latched on accepted start.
- op_b  input  WIDTH  operand B, latched on accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result/flags valid from this cycle.
- result  output  WIDTH  A register contents; final result held until next accepted start.
- cout  output  1  carry out of MSB position (for sub: 1 = no borrow, A ≥ B unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- ser_out  output  1  combinational current sum bit a_reg[0]^b_eff[0]^carry; meaningful only in SHIFT.

## Operation
- Registers: a_reg, b_reg (WIDTH each), sub_r, carry, cnt ($clog2(WIDTH+1) bits), cout, ovf, 2-bit state.
- States: IDLE → SHIFT on start=1; SHIFT → DONE when the WIDTH-th bit is processed; DONE → IDLE unconditionally after one cycle.
- Accept (IDLE, start=1): a_reg←op_a, b_reg←op_b, sub_r←sub, carry←sub (the +1 for two's complement), cnt←0, cout←0, ovf←0.
- Per SHIFT cycle: b_eff = b_reg[0]^sub_r; s = a_reg[0]^b_eff^carry; c = majority(a_reg[0], b_eff, carry).
- Shift: a_reg←{s, a_reg[WIDTH-1:1]}; b_reg←{1'b0, b_reg[WIDTH-1:1]}; carry←c; cnt←cnt+1.
- When cnt = WIDTH−1 (MSB bit): cout←c, ovf←carry^c, state←DONE.
- Arithmetic is modulo 2^WIDTH; no saturation.
- start is ignored in SHIFT and DONE; no queueing. sub, op_a and op_b are don't-care outside the accepting edge.
- Reset (rstn=0 at any edge, including mid-SHIFT): state←IDLE, a_reg, b_reg, carry, cnt, sub_r, cout, ovf ← 0. The operation in progress is discarded, and no done is produced for it.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0; ser_out=0 given zeroed registers.

## Timing
- Edge E0 samples start=1 in IDLE. From E0, busy=1.
- Edges E1..E_WIDTH perform the WIDTH shifts.
- After E_WIDTH, state=DONE: done=1 for exactly one cycle, and result/cout/ovf are final.
- After E_WIDTH+1: IDLE, busy=0, and result/cout/ovf remain held.
- Latency from start edge to done is WIDTH+1 cycles. The earliest next accept is at E_WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- start held high continuously starts back-to-back operations at E0, E_WIDTH+2, and so on.
- done and busy are registered, with no combinational path from inputs. ser_out is combinational from registers only.

## Test plan
- WIDTH=4, sub=1, A=0101, B=0111 → done at start+5 cycles, result=1110, cout=0, ovf=0.
- WIDTH=4, sub=0, A=0111, B=0001 → result=1000, cout=0, ovf=1. Then sub=1, A=1000, B=0001 → result=0111, cout=1, ovf=1.
- WIDTH=4, sub=0, A=1111, B=0001 → result=0000, cout=1, ovf=0. During SHIFT, ser_out sequence LSB-first = 0,0,0,0.
- WIDTH=8, sub=0, A=0xC8, B=0x64 → result=0x2C, cout=1, ovf=0. sub=1, A=0x00, B=0x01 → result=0xFF, cout=0, ovf=0.
- Hold start=1 throughout with new operands each accept → second start ignored while busy; accepts exactly at E0 and E_WIDTH+2; done pulses one cycle each.
- Drive rstn=0 for one edge at the 2nd SHIFT cycle → next cycle busy=0, result=0, no done pulse. A new start then completes correctly, e.g. 0011+0001 → 0100.
